reserved_entry_auth: RTL and testbench
======================================

Name: reserved_entry_auth

Overview:
- Upstream gate stage for the reserved-slot entry checker.
- Takes a flat-number request and a keypad password, validates it against a per-flat password table, and hands downstream a registered (flat_number, pwd_flag) pair over a valid/ready handshake.
- Enforces lockout after repeated failures.
- Downstream indexes slots by flat_number-1, so valid flats are 1..N+1.

Parameters:
- N, `parking_slots: slot count minus one; flats 1..N+1; flat width $clog2(N)+1.
- PWD_DIGITS, 4: BCD digits per password.
- MAX_TRIES, 3: consecutive failures that trigger lockout.
- LOCK_CYCLES, 64: lockout duration in clk cycles.
- TIMEOUT_CYCLES, 256: idle cycles allowed between digits (only with ENTRY_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  entry request present.
- req_flat  in  $clog2(N)+1  requested flat number.
- req_ready  out  1  block can accept a request.
- key_valid  in  1  one keypad digit present this cycle.
- key_digit  in  4  BCD digit, legal range 0..9.
- prog_en  in  1  password table write strobe.
- prog_flat  in  $clog2(N)+1  flat number to program.
- prog_pwd  in  4*PWD_DIGITS  new password, BCD, MSD in the top nibble.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out_flat  out  $clog2(N)+1  flat number forwarded downstream.
- out_pwd_flag  out  1  1 = password correct.
- locked  out  1  lockout active.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: state=IDLE, req_ready=1, out_valid=0, out_flat=0, out_pwd_flag=0, locked=0, fail_cnt=0, digit_cnt=0, entry shift register=0, all password table entries=0 (password "0000"). Reset asserted mid-operation aborts any transaction and discards any pending result.
- States: IDLE, COLLECT, CHECK, RESP, LOCKED.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: latch req_flat, clear the shift register, digit_cnt and bad_digit, then go to COLLECT.
- COLLECT:
  - req_ready=0.
  - Each key_valid cycle: shift key_digit in MSD-first and increment digit_cnt.
  - key_digit>9 sets sticky bad_digit; the digit still counts.
  - When the PWD_DIGITS-th digit is accepted, go to CHECK.
- CHECK (one cycle):
  - match = (1<=flat<=N+1) & ~bad_digit & (entry==table[flat-1]).
  - Register out_flat=flat, out_pwd_flag=match, out_valid=1.
  - On match, fail_cnt=0. Otherwise fail_cnt increments, saturating at MAX_TRIES.
  - Go to RESP.
- Latency: out_valid rises on the 2nd clk edge after the edge that accepted the last digit.
- RESP:
  - out_valid, out_flat and out_pwd_flag hold stable until out_ready. No timeout.
  - On out_valid&out_ready: clear out_valid. Go to LOCKED if fail_cnt==MAX_TRIES, else to IDLE.
  - A failed result (out_pwd_flag=0) is still forwarded so downstream reports denial.
- LOCKED:
  - locked=1, req_ready=0, key_valid ignored.
  - Counter runs LOCK_CYCLES; then fail_cnt=0, locked=0, go to IDLE.
- Ignored inputs: key_valid outside COLLECT; req_valid outside IDLE.
- Programming:
  - prog_en takes effect only in IDLE and LOCKED; otherwise it is ignored and there is no queueing.
  - prog_flat outside 1..N+1 is ignored.
  - prog_en together with an accepted request in the same cycle: the write completes; a later CHECK sees the new value.
- Out-of-range flat (0 or >N+1): the full digit collection still occurs (no information leak), then the result is forced to fail and counts toward lockout.
- fail_cnt is global (not per flat), counts consecutive failures only, and survives across requests.

Optional Feature:
- Macro: ENTRY_TIMEOUT_EN.
- Defined:
  - In COLLECT, a counter reloads on every accepted digit and on COLLECT entry.
  - Reaching TIMEOUT_CYCLES with no digit forces CHECK with match=0.
  - A timeout on the same cycle as a key_valid: the digit wins and the counter reloads.
- Undefined: COLLECT waits indefinitely; no counter logic is generated.

Decomposition:
- Shared package:
  - State encoding enum.
  - DIGIT_W=4.
  - PWD_W=4*PWD_DIGITS.
  - FLAT_W=$clog2(N)+1.
  - BCD_MAX=9.
  - Default PWD "0000".
- Sub-module entry_pwd_table:
  - (N+1)xPWD_W register array with async-reset clear.
  - Write port: prog_en, prog_flat, prog_pwd, including the range check.
  - Read port: flat, returning the password, combinational.
- The FSM, counters and handshake stay in reserved_entry_auth.

Test Plan:
- Program flat 3 = 1234. Request flat 3, keys 1,2,3,4 -> out_valid 2 cycles after the last key, out_flat=3, out_pwd_flag=1, fail_cnt=0.
- Request flat 3, keys 1,2,3,5 three times, each acked -> out_pwd_flag=0 each time; after the 3rd ack locked=1 and req_ready=0 for 64 cycles, then IDLE; during lockout req_valid is not accepted.
- Request flat 0 and flat N+2 with correct-format digits -> out_pwd_flag=0 after 4 digits. Digit 0xA within 1,2,3,A to flat 3 -> out_pwd_flag=0.
- Hold out_ready=0 for 10 cycles in RESP -> out_valid/out_flat/out_pwd_flag stable. Key presses and prog_en during RESP have no effect, and the table is unchanged on readback via a later correct entry.
- Assert rst_n low mid-COLLECT after 2 digits -> outputs immediately at reset values; flat 3 password reverts to 0000 (keys 0,0,0,0 then pass).
- With ENTRY_TIMEOUT_EN: 2 digits then 256 idle cycles -> forced out_pwd_flag=0. Without the macro, the same stimulus gives no output.

Source files
------------

// File: rtl/reserved_entry_auth_pkg.sv
// reserved_entry_auth_pkg: shared types and constants for the reserved-slot entry gate.
`ifndef PARKING_SLOTS
`define PARKING_SLOTS 7
`endif
package reserved_entry_auth_pkg;
  localparam int N = `PARKING_SLOTS;
  localparam int PWD_DIGITS = 4;
  localparam int MAX_TRIES = 3;
  localparam int LOCK_CYCLES = 64;
  localparam int TIMEOUT_CYCLES = 256;
  localparam int DIGIT_W = 4;
  localparam int PWD_W = 4 * PWD_DIGITS;
  localparam int FLAT_W = $clog2(N) + 1;
  localparam int BCD_MAX = 9;
  localparam logic [PWD_W-1:0] DEFAULT_PWD = '0;
  typedef enum logic [2:0] {IDLE, COLLECT, CHECK, RESP, LOCKED} state_t;
endpackage

// File: rtl/reserved_entry_auth_pwd_table.sv
// entry_pwd_table: per-flat password registers, range-checked write, combinational read.
module entry_pwd_table
  import reserved_entry_auth_pkg::*;
#(
  parameter int N = reserved_entry_auth_pkg::N,
  parameter int PWD_DIGITS = reserved_entry_auth_pkg::PWD_DIGITS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      prog_en,
  input  logic [$clog2(N):0]        prog_flat,
  input  logic [4*PWD_DIGITS-1:0]   prog_pwd,
  input  logic [$clog2(N):0]        rd_flat,
  output logic [4*PWD_DIGITS-1:0]   rd_pwd
);
  localparam int FW = $clog2(N) + 1;
  localparam int PW = 4 * PWD_DIGITS;
  logic [PW-1:0] mem [0:N];
  // Flat f lives at mem[f-1]; flats outside 1..N+1 match no entry.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i <= N; i++) mem[i] <= PW'(DEFAULT_PWD);
    else
      for (int i = 0; i <= N; i++)
        if (prog_en && prog_flat == FW'(i + 1)) mem[i] <= prog_pwd;
  always_comb begin
    rd_pwd = '0;
    for (int i = 0; i <= N; i++)
      if (rd_flat == FW'(i + 1)) rd_pwd = mem[i];
  end
endmodule

// File: rtl/reserved_entry_auth.sv
// reserved_entry_auth: flat/password gate with lockout; optional digit timeout via ENTRY_TIMEOUT_EN.
module reserved_entry_auth
  import reserved_entry_auth_pkg::*;
#(
  parameter int N = reserved_entry_auth_pkg::N,
  parameter int PWD_DIGITS = reserved_entry_auth_pkg::PWD_DIGITS,
  parameter int MAX_TRIES = reserved_entry_auth_pkg::MAX_TRIES,
  parameter int LOCK_CYCLES = reserved_entry_auth_pkg::LOCK_CYCLES
`ifdef ENTRY_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = reserved_entry_auth_pkg::TIMEOUT_CYCLES
`endif
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  input  logic [$clog2(N):0]        req_flat,
  output logic                      req_ready,
  input  logic                      key_valid,
  input  logic [3:0]                key_digit,
  input  logic                      prog_en,
  input  logic [$clog2(N):0]        prog_flat,
  input  logic [4*PWD_DIGITS-1:0]   prog_pwd,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(N):0]        out_flat,
  output logic                      out_pwd_flag,
  output logic                      locked
);
  localparam int FW = $clog2(N) + 1;
  localparam int PW = 4 * PWD_DIGITS;
  localparam int DW = $clog2(PWD_DIGITS + 1);
  localparam int CW = $clog2(MAX_TRIES + 1);
  localparam int LW = $clog2(LOCK_CYCLES);
  localparam logic [DW-1:0] D_LAST = DW'(PWD_DIGITS);
  localparam logic [CW-1:0] F_MAX = CW'(MAX_TRIES);
  localparam logic [LW-1:0] L_LAST = LW'(LOCK_CYCLES - 1);
  state_t state;
  logic [FW-1:0] flat_q;
  logic [PW-1:0] entry;
  logic [PW-1:0] tbl_pwd;
  logic [DW-1:0] digit_cnt;
  logic [CW-1:0] fail_cnt;
  logic [LW-1:0] lock_cnt;
  logic bad_digit;
  logic flat_ok;
  logic match;
`ifdef ENTRY_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_cnt;
`endif
  entry_pwd_table #(.N(N), .PWD_DIGITS(PWD_DIGITS)) u_table (
    .clk       (clk),
    .rst_n     (rst_n),
    .prog_en   (prog_en && (state == IDLE || state == LOCKED)),
    .prog_flat (prog_flat),
    .prog_pwd  (prog_pwd),
    .rd_flat   (flat_q),
    .rd_pwd    (tbl_pwd)
  );
  assign flat_ok = flat_q != '0 && flat_q <= FW'(N + 1);
  assign match = flat_ok && !bad_digit && entry == tbl_pwd;
  // The full digit sequence is always collected, even for bad flats, so timing reveals nothing.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      req_ready <= 1'b1;
      out_valid <= 1'b0;
      out_flat <= '0;
      out_pwd_flag <= 1'b0;
      locked <= 1'b0;
      fail_cnt <= '0;
      digit_cnt <= '0;
      entry <= '0;
      flat_q <= '0;
      bad_digit <= 1'b0;
      lock_cnt <= '0;
`ifdef ENTRY_TIMEOUT_EN
      tmo_cnt <= '0;
`endif
    end else
      case (state)
        IDLE:
          if (req_valid) begin
            flat_q <= req_flat;
            entry <= '0;
            digit_cnt <= '0;
            bad_digit <= 1'b0;
            req_ready <= 1'b0;
`ifdef ENTRY_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
            state <= COLLECT;
          end
        COLLECT:
          if (digit_cnt == D_LAST) state <= CHECK;
          else if (key_valid) begin
            entry <= {entry[PW-5:0], key_digit};
            digit_cnt <= digit_cnt + 1'b1;
            bad_digit <= bad_digit | (key_digit > DIGIT_W'(BCD_MAX));
`ifdef ENTRY_TIMEOUT_EN
            tmo_cnt <= '0;
          end else if (tmo_cnt == T_LAST) begin
            bad_digit <= 1'b1;
            state <= CHECK;
          end else tmo_cnt <= tmo_cnt + 1'b1;
`else
          end
`endif
        CHECK: begin
          out_flat <= flat_q;
          out_pwd_flag <= match;
          out_valid <= 1'b1;
          fail_cnt <= match ? '0 : (fail_cnt == F_MAX ? fail_cnt : fail_cnt + 1'b1);
          state <= RESP;
        end
        RESP:
          if (out_ready) begin
            out_valid <= 1'b0;
            if (fail_cnt == F_MAX) begin
              locked <= 1'b1;
              lock_cnt <= '0;
              state <= LOCKED;
            end else begin
              req_ready <= 1'b1;
              state <= IDLE;
            end
          end
        LOCKED:
          if (lock_cnt == L_LAST) begin
            fail_cnt <= '0;
            locked <= 1'b0;
            req_ready <= 1'b1;
            state <= IDLE;
          end else lock_cnt <= lock_cnt + 1'b1;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_reserved_entry_auth.sv
// tb_reserved_entry_auth: scoreboard bench for reserved_entry_auth (honours ENTRY_TIMEOUT_EN).
module tb_reserved_entry_auth;
  import reserved_entry_auth_pkg::*;
  localparam int FW = $clog2(N) + 1;
  typedef struct packed {logic [FW-1:0] flat; logic flag;} exp_t;
  logic clk = 0, rst_n = 0;
  logic req_valid = 0, req_ready, key_valid = 0, prog_en = 0, out_valid, out_ready = 0;
  logic out_pwd_flag, locked;
  logic [FW-1:0] req_flat = '0, prog_flat = '0, out_flat;
  logic [3:0] key_digit = '0;
  logic [15:0] prog_pwd = '0;
  exp_t sb[$];
  logic [15:0] mtab [0:15];
  int mfail = 0;
  int vectors = 0, miscompares = 0;
  reserved_entry_auth dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_flat(req_flat), .req_ready(req_ready),
    .key_valid(key_valid), .key_digit(key_digit), .prog_en(prog_en), .prog_flat(prog_flat),
    .prog_pwd(prog_pwd), .out_valid(out_valid), .out_ready(out_ready), .out_flat(out_flat),
    .out_pwd_flag(out_pwd_flag), .locked(locked)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic exp_flag(input logic [FW-1:0] f, input logic [15:0] p);
    logic ok = f >= 1 && f <= FW'(N + 1);
    for (int i = 0; i < 4; i++) if (p[i*4+:4] > 4'd9) ok = 0;
    return ok && p == mtab[f];
  endfunction
  task automatic prog(input logic [FW-1:0] f, input logic [15:0] p);
    prog_en = 1; prog_flat = f; prog_pwd = p;
    @(negedge clk);
    prog_en = 0;
    if (f >= 1 && f <= FW'(N + 1)) mtab[f] = p;
  endtask
  task automatic request(input logic [FW-1:0] f, input bit wp, input logic [FW-1:0] pf, input logic [15:0] pp);
    check("req_ready", req_ready, 1);
    req_valid = 1; req_flat = f;
    if (wp) begin prog_en = 1; prog_flat = pf; prog_pwd = pp; end
    @(negedge clk);
    req_valid = 0; prog_en = 0;
    if (wp && pf >= 1 && pf <= FW'(N + 1)) mtab[pf] = pp;
  endtask
  task automatic keys(input logic [15:0] p, input int cnt);
    for (int i = 3; i > 3 - cnt; i--) begin
      key_valid = 1; key_digit = p[i*4+:4];
      @(negedge clk);
    end
    key_valid = 0;
  endtask
  task automatic entry(input logic [FW-1:0] f, input logic [15:0] p, input bit wp, input logic [FW-1:0] pf, input logic [15:0] pp);
    request(f, wp, pf, pp);
    keys(p, 4);
    sb.push_back('{flat: f, flag: exp_flag(f, p)});
  endtask
  task automatic get_resp(input bit lat_chk, input int bound, input int hold);
    int n = 0;
    bit bad = 0;
    exp_t e;
    while (!out_valid && n < bound) begin @(negedge clk); n++; end
    if (!out_valid) begin check("resp_timeout", 0, 1); return; end
    if (lat_chk) check("latency", n, 2);
    e = sb.pop_front();
    check("out_flat", out_flat, e.flat);
    check("out_pwd_flag", out_pwd_flag, e.flag);
    for (int i = 0; i < hold; i++) begin
      key_valid = 1; key_digit = 4'd7; prog_en = 1; prog_flat = 3; prog_pwd = 16'h5555;
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_flat", out_flat, e.flat);
      check("hold_flag", out_pwd_flag, e.flag);
    end
    key_valid = 0; prog_en = 0;
    mfail = e.flag ? 0 : (mfail < MAX_TRIES ? mfail + 1 : mfail);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    check("out_valid_clr", out_valid, 0);
    check("locked", locked, mfail == MAX_TRIES);
    if (mfail == MAX_TRIES) begin
      n = 0;
      while (locked && n < 200) begin
        req_valid = n < 60; req_flat = 3;
        prog_en = n == 5; prog_flat = 5; prog_pwd = 16'h9876;
        if (req_ready) bad = 1;
        @(negedge clk);
        n++;
      end
      req_valid = 0; prog_en = 0;
      mtab[5] = 16'h9876;
      mfail = 0;
      check("lock_len", n, LOCK_CYCLES);
      check("lock_rr_low", bad, 0);
      check("unlock_rr", req_ready, 1);
      check("unlock_valid", out_valid, 0);
    end
  endtask
  initial begin
    for (int i = 0; i < 16; i++) mtab[i] = '0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_flat", out_flat, 0);
    check("rst_flag", out_pwd_flag, 0);
    check("rst_locked", locked, 0);
    rst_n = 1;
    @(negedge clk);
    prog(3, 16'h1234);
    entry(3, 16'h1234, 0, 0, 0); get_resp(1, 20, 0);
    repeat (3) begin entry(3, 16'h1235, 0, 0, 0); get_resp(1, 20, 0); end
    entry(0, 16'h0000, 0, 0, 0); get_resp(1, 20, 0);
    entry(FW'(N + 2), 16'h0000, 0, 0, 0); get_resp(1, 20, 0);
    entry(3, 16'h123A, 0, 0, 0); get_resp(1, 20, 0);
    entry(5, 16'h9876, 0, 0, 0); get_resp(1, 20, 0);
    entry(3, 16'h1234, 0, 0, 0); get_resp(1, 20, 10);
    entry(2, 16'h4321, 1, 2, 16'h4321); get_resp(1, 20, 0);
    entry(3, 16'h1234, 0, 0, 0); get_resp(1, 20, 0);
    entry(7, 16'h9999, 0, 0, 0); get_resp(1, 20, 0);
`ifdef ENTRY_TIMEOUT_EN
    request(3, 0, 0, 0); keys(16'h1200, 2);
    sb.push_back('{flat: 3, flag: 1'b0});
    get_resp(0, 400, 0);
    request(3, 0, 0, 0); keys(16'h1200, 2);
`else
    begin
      bit seen = 0;
      request(3, 0, 0, 0); keys(16'h1200, 2);
      repeat (400) begin @(negedge clk); if (out_valid) seen = 1; end
      check("no_timeout_out", seen, 0);
    end
`endif
    #2 rst_n = 0;
    #1;
    check("arst_req_ready", req_ready, 1);
    check("arst_out_valid", out_valid, 0);
    check("arst_out_flat", out_flat, 0);
    check("arst_flag", out_pwd_flag, 0);
    check("arst_locked", locked, 0);
    for (int i = 0; i < 16; i++) mtab[i] = '0;
    mfail = 0;
    sb.delete();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    entry(3, 16'h0000, 0, 0, 0); get_resp(1, 20, 0);
    entry(3, 16'h1234, 0, 0, 0); get_resp(1, 20, 0);
    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
